// File: rtl/rgb_cmp_pkg.sv
// Shared types for the RGB comparator/PWM LED driver: compare codes,
// FSM states and the LED channel map.
package rgb_cmp_pkg;

  // Compare result codes as seen on the result port.
  typedef enum logic [1:0] {
    NONE = 2'b00,
    LT   = 2'b01,
    EQ   = 2'b10,
    GT   = 2'b11
  } cmp_res_t;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // LED channel indices inside the packed LED vectors.
  localparam int NUM_CH = 3;
  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;

  // Compare code that lights a given channel: red=A>B, green=A==B, blue=A<B.
  function automatic cmp_res_t ch_code(input int ch);
    case (ch)
      CH_R:    return GT;
      CH_G:    return EQ;
      default: return LT;
    endcase
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter. pwm_on is high while the count is below duty;
// wrap pulses for the single cycle in which the counter sits at its maximum,
// i.e. just before it rolls over to zero.
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on,
  output logic                wrap
);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;

  // Counter advances every clock and wraps naturally; nothing else clears it.
  always_comb begin
    cnt_d = cnt_q + PWM_BITS'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pwm_on = (cnt_q < duty);
  assign wrap   = &cnt_q;

endmodule

// File: rtl/rgb_cmp_pwm.sv
// RGB LED comparator driver: accepts an operand pair over valid/ready,
// latches the unsigned compare result and a PWM duty, and shows the result
// on one LED channel for at least HOLD_CYCLES clocks.
// Optional feature: define RGB_CMP_BLINK_EN to make the green (A==B)
// channel blink, toggling on every PWM period wrap.
module rgb_cmp_pwm #(
  parameter int WIDTH       = 4,
  parameter int PWM_BITS    = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [PWM_BITS-1:0] duty,
  output logic [1:0]          result,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b
);

  import rgb_cmp_pkg::*;

  // Hold counter only needs to represent HOLD_CYCLES-1.
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_t              state_q, state_d;
  cmp_res_t            result_q, result_d;
  cmp_res_t            cmp_now;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                rdy_q, rdy_d;
  logic                accept;
  logic                pwm_on;
  logic                pwm_wrap;
  logic [NUM_CH-1:0]   ch_en;
  logic [NUM_CH-1:0]   led_d;
  logic [NUM_CH-1:0]   led_q;

  // Ready is registered so it stays low while reset is asserted and rises
  // on the first clock after release.
  assign accept = in_valid && rdy_q;

  // Full-width unsigned compare of the incoming operands.
  always_comb begin
    if (a > b) begin
      cmp_now = GT;
    end else if (a == b) begin
      cmp_now = EQ;
    end else begin
      cmp_now = LT;
    end
  end

  // Next-state logic: an accept (re)loads result, duty and the hold timer;
  // otherwise the timer counts down and saturates at zero.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    duty_d   = duty_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SHOW;
          result_d = cmp_now;
          duty_d   = duty;
          hold_d   = HOLD_LOAD;
        end
      end
      SHOW: begin
        if (accept) begin
          result_d = cmp_now;
          duty_d   = duty;
          hold_d   = HOLD_LOAD;
        end else if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdy_d = (state_d == IDLE) || (hold_d == '0);
  end

  // FSM, result, duty and hold timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= NONE;
      duty_q   <= '0;
      hold_q   <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      duty_q   <= duty_d;
      hold_q   <= hold_d;
      rdy_q    <= rdy_d;
    end
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .duty   (duty_q),
    .pwm_on (pwm_on),
    .wrap   (pwm_wrap)
  );

`ifdef RGB_CMP_BLINK_EN
  logic blink_q, blink_d;

  // Blink phase restarts lit on every accept, then flips each PWM wrap while showing EQ.
  always_comb begin
    blink_d = blink_q;
    if (accept) begin
      blink_d = 1'b1;
    end else if (pwm_wrap && (result_q == EQ)) begin
      blink_d = ~blink_q;
    end
  end

  // Blink phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b1;
    end else begin
      blink_q <= blink_d;
    end
  end

  // Only green is gated by the blink phase.
  always_comb begin
    ch_en       = '1;
    ch_en[CH_G] = blink_q;
  end
`else
  logic unused_wrap;
  assign unused_wrap = pwm_wrap;
  assign ch_en       = '1;
`endif

  // One LED per compare code; at most one matches, NONE lights nothing.
  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_led
    localparam cmp_res_t CODE = ch_code(gi);
    assign led_d[gi] = pwm_on && (result_q == CODE) && ch_en[gi];
  end

  // LED output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign in_ready = rdy_q;
  assign result   = result_q;
  assign led_r    = led_q[CH_R];
  assign led_g    = led_q[CH_G];
  assign led_b    = led_q[CH_B];

endmodule
